spi_xfer_arbiter: RTL

//  Shares one byte-level SPI master among NUM_REQ requesters. Round-robin grant, per-requester

---
 rtl/spi_arb_pkg.sv | 14 +
 rtl/spi_rr_arbiter.sv | 33 +++
 rtl/spi_xfer_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transfer arbiter: byte width and FSM state encodings.
package spi_arb_pkg;

  localparam int BYTE_W = 8;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 3'd0;
  localparam arb_state_t ST_SETUP = 3'd1;
  localparam arb_state_t ST_XFER  = 3'd2;
  localparam arb_state_t ST_WAIT  = 3'd3;
  localparam arb_state_t ST_HOLD  = 3'd4;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or after the pointer,
// as a one-hot vector plus a valid flag.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid
);

  int               w_sum;
  logic [PTR_W-1:0] w_idx;

  // Scan requesters starting at the pointer, wrapping once around the vector
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_sum = int'(i_ptr) + off;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = PTR_W'(w_sum);
      if (!o_valid && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one byte-level SPI master among NUM_REQ requesters with round-robin grant and
// chip-select setup/hold sequencing. Optional WAIT watchdog enabled by SPI_ARB_WDOG_EN.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LEN_W       = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
  input  logic [NUM_REQ*BYTE_W-1:0] i_tx_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_tx_ready,
  output logic [BYTE_W-1:0]         o_rx_data,
  output logic [NUM_REQ-1:0]        o_rx_valid,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [NUM_REQ-1:0]        o_err,
  output logic [NUM_REQ-1:0]        o_spi_cs_n,
  output logic                      o_mst_start,
  output logic [BYTE_W-1:0]         o_mst_tx,
  input  logic                      i_mst_busy,
  input  logic                      i_mst_done,
  input  logic [BYTE_W-1:0]         i_mst_rx
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_cs_n;
  logic [PTR_W-1:0]    r_ptr;
  logic [LEN_W-1:0]    r_bytes_left;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mst_start;
  logic [BYTE_W-1:0]   r_mst_tx;
  logic [NUM_REQ-1:0]  r_tx_ready;
  logic [BYTE_W-1:0]   r_rx_data;
  logic [NUM_REQ-1:0]  r_rx_valid;
  logic [NUM_REQ-1:0]  r_done;

  logic [NUM_REQ-1:0]  w_pick;
  logic                w_pick_valid;
  logic [LEN_W-1:0]    w_len_pick;
  logic [BYTE_W-1:0]   w_tx_sel;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [PTR_W-1:0]    w_next_ptr;

`ifdef SPI_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]   r_wdog;
  logic                r_abort;
  logic [NUM_REQ-1:0]  r_err;
`endif

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick),
    .o_valid (w_pick_valid)
  );

  // Steer the winner's length, the granted requester's TX byte and the granted index
  always_comb begin
    w_len_pick = '0;
    w_tx_sel   = '0;
    w_gnt_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_len_pick = i_req_len[i*LEN_W +: LEN_W];
      if (r_gnt[i]) begin
        w_tx_sel  = i_tx_data[i*BYTE_W +: BYTE_W];
        w_gnt_idx = PTR_W'(i);
      end
    end
    w_next_ptr = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
  end

  // Transaction sequencer: grant, cs setup, byte starts, completion wait, cs hold
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_cs_n       <= '1;
      r_ptr        <= '0;
      r_bytes_left <= '0;
      r_cnt        <= '0;
      r_mst_start  <= 1'b0;
      r_mst_tx     <= '0;
      r_tx_ready   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= '0;
      r_done       <= '0;
`ifdef SPI_ARB_WDOG_EN
      r_wdog       <= '0;
      r_abort      <= 1'b0;
      r_err        <= '0;
`endif
    end else begin
      r_mst_start <= 1'b0;
      r_tx_ready  <= '0;
      r_rx_valid  <= '0;
      r_done      <= '0;
`ifdef SPI_ARB_WDOG_EN
      r_err       <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gnt        <= w_pick;
            r_cs_n       <= ~w_pick;
            r_bytes_left <= w_len_pick;
            r_cnt        <= CNT_W'(CS_SETUP);
            r_state      <= ST_SETUP;
`ifdef SPI_ARB_WDOG_EN
            r_abort      <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (!i_mst_busy) begin
            r_mst_start <= 1'b1;
            r_mst_tx    <= w_tx_sel;
            r_tx_ready  <= r_gnt;
            r_state     <= ST_WAIT;
`ifdef SPI_ARB_WDOG_EN
            r_wdog      <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (i_mst_done) begin
            r_rx_data  <= i_mst_rx;
            r_rx_valid <= r_gnt;
            if (r_bytes_left == '0) begin
              r_cnt   <= CNT_W'(CS_HOLD);
              r_state <= ST_HOLD;
            end else begin
              r_bytes_left <= r_bytes_left - LEN_W'(1);
              r_state      <= ST_XFER;
            end
          end
`ifdef SPI_ARB_WDOG_EN
          else if (r_wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
            r_abort <= 1'b1;
            r_cnt   <= CNT_W'(CS_HOLD);
            r_state <= ST_HOLD;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
`endif
        end
        ST_HOLD: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_cs_n  <= '1;
            r_gnt   <= '0;
            r_done  <= r_gnt;
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
`ifdef SPI_ARB_WDOG_EN
            r_err   <= r_abort ? r_gnt : '0;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_spi_cs_n  = r_cs_n;
  assign o_mst_start = r_mst_start;
  assign o_mst_tx    = r_mst_tx;
  assign o_tx_ready  = r_tx_ready;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_done      = r_done;
`ifdef SPI_ARB_WDOG_EN
  assign o_err       = r_err;
`else
  assign o_err       = '0;
`endif

endmodule
